// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier datapath.
`default_nettype none

package booth_pkg;

  localparam int K_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/parallel_adder.sv
// K-bit add/subtract stage: out = y + x when c3=0, y - x when c3=1.
`default_nettype none

module parallel_adder #(
  parameter int K = 8
) (
  input  logic [K-1:0] x,
  input  logic [K-1:0] y,
  input  logic         c3,
  output logic [K-1:0] out
);

  // Two's-complement subtract: invert x and inject c3 as the carry-in.
  assign out = y + (x ^ {K{c3}}) + {{(K-1){1'b0}}, c3};

endmodule

`default_nettype wire

// File: rtl/booth_radix2_seq.sv
// Sequential radix-2 Booth signed multiplier (A/Q/Q-1/M registers, counter, FSM).
// Optional BOOTH_SKIP_EN: bypass the ADD cycle when the Booth pair is 00 or 11.
`default_nettype none

module booth_radix2_seq
  import booth_pkg::*;
#(
  parameter int K     = K_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           start,
  input  logic [K-1:0]   x,
  input  logic [K-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*K-1:0] product
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [K-1:0]     a;
  logic [K-1:0]     q;
  logic [K-1:0]     m;
  logic             q_1;
  logic             sgn;
  logic [CNT_W-1:0] cnt;

  logic [1:0]   pair;
  logic         sub_op;
  logic         do_op;
  logic [K-1:0] sum;
  logic         mx_msb;
  logic         ovf;
  logic [K-1:0] a_sh;
  logic [K-1:0] q_sh;

  assign pair   = {q[0], q_1};
  assign sub_op = (pair == 2'b10);
  assign do_op  = (pair == 2'b10) || (pair == 2'b01);

  parallel_adder #(.K(K)) u_adder (
    .x  (m),
    .y  (a),
    .c3 (sub_op),
    .out(sum)
  );

  // True sign of A+/-M survives the K-bit overflow (e.g. M = -2^(K-1)).
  assign mx_msb = m[K-1] ^ sub_op;
  assign ovf    = (a[K-1] == mx_msb) && (sum[K-1] != a[K-1]);

  assign a_sh = {sgn, a[K-1:1]};
  assign q_sh = {a[0], q[K-1:1]};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      q_1     <= 1'b0;
      sgn     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m    <= x;
            q    <= y;
            a    <= '0;
            q_1  <= 1'b0;
            sgn  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef BOOTH_SKIP_EN
            state <= y[0] ? ST_ADD : ST_SHIFT;
`else
            state <= ST_ADD;
`endif
          end
        end
        ST_ADD: begin
          if (do_op) begin
            a   <= sum;
            sgn <= sum[K-1] ^ ovf;
          end else begin
            sgn <= a[K-1];
          end
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          a   <= a_sh;
          q   <= q_sh;
          q_1 <= q[0];
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            product <= {a_sh, q_sh};
          end else begin
`ifdef BOOTH_SKIP_EN
            // Next pair is {q[1], q[0]}; sgn already equals the shifted-in MSB.
            state <= (q[1] == q[0]) ? ST_SHIFT : ST_ADD;
`else
            state <= ST_ADD;
`endif
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
